dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Sequencer for the DDS sine generator: produces its periodic `sampling_pulse` and drives its 22-bit phase increment `K` through a linear frequency sweep. Each sweep runs from `k_start` to `k_stop` in increments of `k_step`, holding each frequency for a programmed number of samples. The block sits between the configuration/control logic and the DDS core. It consumes the core's `new_sample_ready` to decide when the last sample has landed.

## Interface
- `DIV_W`, 16: width of the sample-period divider value.
- `CNT_W`, 16: width of the dwell and step counters.

- `clk`  in  1  system clock, sole clock domain.
- `reset`  in  1  synchronous, active-high; clears all state on the rising edge of `clk`.
- `start`  in  1  start request; accepted only in IDLE.
- `abort`  in  1  terminates a sweep; wins over `start`.
- `k_start`  in  22  first phase increment.
- `k_stop`  in  22  upper bound on phase increment, inclusive.
- `k_step`  in  22  increment added per step.
- `div`  in  DIV_W  sample period in clocks.
- `dwell`  in  CNT_W  samples per frequency step.
- `new_sample_ready`  in  1  from DDS; high one cycle after each `sampling_pulse`.
- `K`  out  22  phase increment to DDS.
- `sampling_pulse`  out  1  one-cycle sample strobe to DDS.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at normal sweep completion.
- `step_idx`  out  CNT_W  number of completed frequency steps in the current sweep.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `start`=1 and `abort`=0: latch `k_start`, `k_stop`, `k_step`, `div`, `dwell` into shadow registers; `K`<=`k_start`; clear the divider, dwell counter and `step_idx`; go to RUN.
  - Inputs are ignored outside this capture edge.
- **Clamps:** shadow `div`<2 is treated as 2; shadow `dwell`=0 is treated as 1.
- **RUN**
  - The divider counts 0..div-1. `sampling_pulse`=1 on the cycle the count equals div-1; the count then wraps to 0.
  - On each pulse edge the dwell counter increments.
  - On the pulse edge that completes `dwell` samples:
    - The dwell counter clears and `step_idx` increments.
    - Next frequency is computed as a 23-bit sum: `K`+`k_step`.
    - If the sum ≤ `k_stop` and `k_step`≠0, `K` <= sum and RUN continues.
    - Otherwise this was the final step: `K` holds and the FSM goes to DRAIN.
  - `K` updates on the same edge on which the DDS samples the pulse. The DDS therefore always consumes the old `K` for that pulse, and `K` is stable for all `dwell` samples of a step.
  - If `k_start`>`k_stop`, exactly one step runs at `k_start`.
- **DRAIN**
  - No further `sampling_pulse`.
  - On `new_sample_ready`=1: `done`=1 for the next cycle, go to IDLE.
- **Abort:** `abort`=1 in RUN or DRAIN → IDLE on the next edge. `sampling_pulse` is forced 0 in that cycle, `done` is not pulsed, and `K` and `step_idx` hold.
- **Busy/start:** `busy` is the registered state ≠ IDLE. `start` while busy is ignored.
- **Reset:** applies in any state, mid-sweep included; returns to IDLE next edge with no `done`.

## Timing
- **Reset values:** `K`=0, `sampling_pulse`=0, `busy`=0, `done`=0, `step_idx`=0, state IDLE.
- All outputs are registered; no combinational path from input to output.
- Start accepted at edge t0 → `busy`=1 from t0.
- First `sampling_pulse` is high in the cycle beginning at edge t0+div-1.
- Pulses then repeat exactly every `div` cycles.
- `K` changes only on the edge ending a step's last pulse cycle.
- Final pulse → DRAIN edge; the DDS `new_sample_ready` follows one cycle later; `done` goes high on the next edge; IDLE is entered on the same edge.
- **Restart:** a new `start` is accepted on the first IDLE cycle, so back-to-back sweeps are possible with one idle cycle.
- **Step count:** sweep length is steps × dwell × div clocks, where steps = floor((k_stop−k_start)/k_step)+1.

## Configuration
- **`SWEEP_LOOP_EN` defined:**
  - At the final step, `K` <= shadow `k_start`, `step_idx` clears, and RUN continues; the pulse cadence is unbroken.
  - DRAIN is never entered and `done` never pulses.
  - Only `abort` or `reset` ends the sweep.
- **Undefined:** single-shot behaviour as described above.

## Test plan
- **Reset:** reset mid-RUN (div=4, dwell=2) → next cycle all outputs 0, state IDLE, no `done`.
- **Basic sweep:** k_start=100, k_step=50, k_stop=200, dwell=2, div=4.
  - Required: 6 pulses, 4 clocks apart; `K` sequence 100,100,150,150,200,200.
  - `step_idx` ends at 3; `done` pulses once, 2 cycles after the last pulse.
- **Overflow guard:** k_start=22'h3FFFF0, k_step=32, k_stop=22'h3FFFFF, dwell=1, div=2 → exactly 1 pulse; `K` never wraps.
- **Clamping:** k_step=0 with dwell=0 and div=1 → single pulse at `k_start`, behaving as dwell=1 and div=2; `done` follows.
- **Abort and start priority:** abort on the cycle of the 3rd pulse → that pulse suppressed, IDLE next edge, `K` holds, no `done`. Then `start` and `abort` asserted together in IDLE → start ignored.
- **Loop mode:** with `SWEEP_LOOP_EN`, basic-sweep config runs 12 pulses → `K` wraps 200→100 with no gap, no `done`; abort → IDLE.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: DDS sample-pulse generator and linear phase-increment sweep.
// Optional SWEEP_LOOP_EN: restart from k_start at the end instead of stopping.
module dds_sweep_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [21:0]      k_start,
  input  logic [21:0]      k_stop,
  input  logic [21:0]      k_step,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] dwell,
  input  logic             new_sample_ready,
  output logic [21:0]      K,
  output logic             sampling_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q;
  logic [21:0]      k_q;
  logic [21:0]      kstop_q;
  logic [21:0]      kstep_q;
`ifdef SWEEP_LOOP_EN
  logic [21:0]      kstart_q;
`endif
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] divcnt_q;
  logic [DIV_W-1:0] divcnt_d;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwlcnt_q;
  logic [CNT_W-1:0] step_q;
  logic             pulse_q;
  logic             done_q;
  logic [22:0]      sum_d;
  logic             more_d;
  logic             last_d;
  logic             pulse_d;

  assign K              = k_q;
  assign sampling_pulse = pulse_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign step_idx       = step_q;

  // Divider wrap, next-pulse flag and 23-bit candidate frequency
  always_comb begin
    sum_d    = {1'b0, k_q} + {1'b0, kstep_q};
    more_d   = (sum_d <= {1'b0, kstop_q}) && (kstep_q != '0);
    last_d   = (dwlcnt_q == dwell_q - CNT_W'(1));
    pulse_d  = (divcnt_q == div_q - DIV_W'(2));
    divcnt_d = (divcnt_q == div_q - DIV_W'(1)) ? '0
             : divcnt_q + DIV_W'(1);
  end

  // Sweep FSM with registered pulse, done, K and step count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      kstop_q  <= '0;
      kstep_q  <= '0;
`ifdef SWEEP_LOOP_EN
      kstart_q <= '0;
`endif
      div_q    <= '0;
      divcnt_q <= '0;
      dwell_q  <= '0;
      dwlcnt_q <= '0;
      step_q   <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
`ifdef SWEEP_LOOP_EN
            kstart_q <= k_start;
`endif
            kstop_q  <= k_stop;
            kstep_q  <= k_step;
            div_q    <= (div < DIV_W'(2)) ? DIV_W'(2) : div;
            dwell_q  <= (dwell == '0) ? CNT_W'(1) : dwell;
            k_q      <= k_start;
            divcnt_q <= '0;
            dwlcnt_q <= '0;
            step_q   <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            divcnt_q <= divcnt_d;
            pulse_q  <= pulse_d;
            if (pulse_q) begin
              if (last_d) begin
                dwlcnt_q <= '0;
                step_q   <= step_q + CNT_W'(1);
                if (more_d) begin
                  k_q <= sum_d[21:0];
                end else begin
`ifdef SWEEP_LOOP_EN
                  k_q    <= kstart_q;
                  step_q <= '0;
`else
                  pulse_q <= 1'b0;
                  state_q <= DRAIN;
`endif
                end
              end else begin
                dwlcnt_q <= dwlcnt_q + CNT_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (new_sample_ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench for dds_sweep_ctrl.
// Expected pulses/done events are queued by stimulus, checked by a monitor.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [21:0] k_start = '0;
  logic [21:0] k_stop = '0;
  logic [21:0] k_step = '0;
  logic [15:0] div = '0;
  logic [15:0] dwell = '0;
  logic        nsr = 1'b0;
  logic [21:0] K;
  logic        sampling_pulse;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    int cyc;
    int val;
  } ev_t;

  ev_t q[$];
  ev_t e;

  dds_sweep_ctrl #(.DIV_W(16), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .k_start(k_start),
    .k_stop(k_stop),
    .k_step(k_step),
    .div(div),
    .dwell(dwell),
    .new_sample_ready(nsr),
    .K(K),
    .sampling_pulse(sampling_pulse),
    .busy(busy),
    .done(done),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DDS model: new_sample_ready one cycle after each pulse
  always @(posedge clk) nsr <= sampling_pulse;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic void push(input bit d, input int c,
                               input int v);
    ev_t x;
    x.is_done = d;
    x.cyc = c;
    x.val = v;
    q.push_back(x);
  endfunction

  // Monitor: every pulse or done must match the queue head
  always @(negedge clk) begin
    if (sampling_pulse === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: pulse=%0b done=%0b K=%0h cycle %0d",
                 sampling_pulse, done, K, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", longint'(done), longint'(e.is_done));
        chk("event_cycle", cyc, e.cyc);
        if (e.is_done) chk("done_step_idx", step_idx, e.val);
        else chk("pulse_K", K, e.val);
      end
    end
  end

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_sweep(input logic [21:0] ks,
                             input logic [21:0] kst,
                             input logic [21:0] ksp,
                             input logic [15:0] dv,
                             input logic [15:0] dw,
                             output int t0);
    k_start = ks;
    k_step = kst;
    k_stop = ksp;
    div = dv;
    dwell = dw;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic drain_check(input string name);
    int i = 0;
    while (q.size() != 0 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_K", K, 0);
    chk("rst_pulse", sampling_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a run
    start_sweep(22'd100, 22'd50, 22'd200, 16'd4, 16'd2, t0);
    chk("busy_at_start", busy, 1);
    push(0, t0 + 3, 100);
    push(0, t0 + 7, 100);
    go_to(t0 + 9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_K", K, 0);
    chk("midrst_pulse", sampling_pulse, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_step", step_idx, 0);
    go_to(t0 + 25);
    drain_check("drain_reset");

`ifdef SWEEP_LOOP_EN
    // Loop mode: 12 pulses with K wrapping, then abort
    start_sweep(22'd100, 22'd50, 22'd200, 16'd4, 16'd2, t0);
    for (int i = 0; i < 12; i++)
      push(0, t0 + 3 + 4 * i, 100 + 50 * ((i % 6) / 2));
    go_to(t0 + 49);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("loop_abort_busy", busy, 0);
    chk("loop_K_wrapped", K, 100);
    chk("loop_step_clear", step_idx, 0);
    go_to(t0 + 65);
    drain_check("drain_loop");
`else
    // Basic sweep: 100,150,200 with dwell 2, div 4
    start_sweep(22'd100, 22'd50, 22'd200, 16'd4, 16'd2, t0);
    for (int i = 0; i < 6; i++)
      push(0, t0 + 3 + 4 * i, 100 + 50 * (i / 2));
    push(1, t0 + 25, 3);
    go_to(t0 + 24);
    chk("basic_busy_drain", busy, 1);
    go_to(t0 + 25);
    chk("basic_idle", busy, 0);
    chk("basic_K_end", K, 200);
    chk("basic_step_end", step_idx, 3);

    // Back-to-back start: overflow guard near the top of K
    start_sweep(22'h3FFFF0, 22'd32, 22'h3FFFFF, 16'd2, 16'd1, t0);
    push(0, t0 + 1, 32'h3FFFF0);
    push(1, t0 + 3, 1);
    go_to(t0 + 3);
    chk("ovf_K_hold", K, 22'h3FFFF0);
    chk("ovf_idle", busy, 0);
    go_to(t0 + 4);

    // Clamping: step 0, dwell 0, div 1
    start_sweep(22'd500, 22'd0, 22'd1000, 16'd1, 16'd0, t0);
    push(0, t0 + 1, 500);
    push(1, t0 + 3, 1);
    go_to(t0 + 3);
    chk("clamp_K", K, 500);
    go_to(t0 + 8);
    drain_check("drain_single");
`endif

    // Abort just before the 3rd pulse
    start_sweep(22'd100, 22'd50, 22'd200, 16'd4, 16'd2, t0);
    push(0, t0 + 3, 100);
    push(0, t0 + 7, 100);
    go_to(t0 + 10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pulse", sampling_pulse, 0);
    chk("abort_K_hold", K, 150);
    chk("abort_step_hold", step_idx, 1);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("startabort_busy", busy, 0);
    chk("startabort_K", K, 150);
    go_to(t0 + 30);
    drain_check("drain_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
